// File: rtl/pc_unit.sv
// Program-counter unit: holds the fetch address, selects the next address by
// fixed priority (exception, stall, return, jump, branch, sequential) and owns
// a small circular return-address stack for call/return.
module pc_unit #(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STEP         = 1,
    parameter int unsigned RESET_VECTOR = 0,
    parameter int unsigned EXC_VECTOR   = 10'h3F0,
    parameter int unsigned RAS_DEPTH    = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              PC_write,
    input  logic              exc_req,
    input  logic              ret_req,
    input  logic              jump_req,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              call,
    input  logic              branch_req,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] PC_current,
    output logic [ADDR_W-1:0] PC_seq,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow,
    output logic              ras_underflow
);

    localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_VECTOR);
    localparam logic [ADDR_W-1:0] EXC_PC  = ADDR_W'(EXC_VECTOR);
    localparam logic [ADDR_W-1:0] STEP_W  = ADDR_W'(STEP);
    localparam logic [PTR_W:0]    CNT_MAX = (PTR_W + 1)'(RAS_DEPTH);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W:0]    cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]  top_idx;
    logic              push;

    // Sequential address and stack status derive directly from registered state.
    always_comb begin
        PC_seq        = pc_q + STEP_W;
        top_idx       = ptr_q - PTR_W'(1);
        PC_current    = pc_q;
        ras_empty     = (cnt_q == '0);
        ras_full      = (cnt_q == CNT_MAX);
        ras_overflow  = ovf_q;
        ras_underflow = unf_q;
    end

    // Next-PC selection and stack bookkeeping by fixed priority.
    always_comb begin
        pc_d  = pc_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (exc_req) begin
            pc_d = EXC_PC;
        end else if (!PC_write) begin
            pc_d = pc_q;
        end else if (ret_req) begin
            if (cnt_q != '0) begin
                pc_d  = ras_mem[top_idx];
                ptr_d = top_idx;
                cnt_d = cnt_q - (PTR_W + 1)'(1);
            end else begin
                pc_d  = PC_seq;
                unf_d = 1'b1;
            end
        end else if (jump_req) begin
            pc_d = jump_target;
            if (call) begin
                push  = 1'b1;
                ptr_d = ptr_q + PTR_W'(1);
                // A push into a full stack overwrites the oldest entry.
                if (cnt_q == CNT_MAX) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + (PTR_W + 1)'(1);
                end
            end
        end else if (branch_req) begin
            pc_d = branch_target;
        end else begin
            pc_d = PC_seq;
        end
    end

    // PC, stack pointer/count and sticky flags with synchronous reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pc_q  <= RST_PC;
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Stack storage; the link address is the sequential successor of the call.
    always_ff @(posedge clock) begin
        if (reset_n && push) begin
            ras_mem[ptr_q] <= PC_seq;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios with literal expectations
// plus randomized traffic checked every cycle against a queue-based model.
module tb_pc_unit;

    localparam int AW    = 10;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << AW;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          PC_write;
    logic          exc_req;
    logic          ret_req;
    logic          jump_req;
    logic [AW-1:0] jump_target;
    logic          call;
    logic          branch_req;
    logic [AW-1:0] branch_target;
    logic [AW-1:0] PC_current;
    logic [AW-1:0] PC_seq;
    logic          ras_empty;
    logic          ras_full;
    logic          ras_overflow;
    logic          ras_underflow;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int m_pc;
    int m_ras[$];
    bit m_ovf;
    bit m_unf;

    pc_unit #(
        .ADDR_W       (AW),
        .STEP         (1),
        .RESET_VECTOR (0),
        .EXC_VECTOR   (10'h3F0),
        .RAS_DEPTH    (DEPTH)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .PC_write      (PC_write),
        .exc_req       (exc_req),
        .ret_req       (ret_req),
        .jump_req      (jump_req),
        .jump_target   (jump_target),
        .call          (call),
        .branch_req    (branch_req),
        .branch_target (branch_target),
        .PC_current    (PC_current),
        .PC_seq        (PC_seq),
        .ras_empty     (ras_empty),
        .ras_full      (ras_full),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    // Architectural next-state rule applied to the inputs sampled at this edge.
    task automatic model_step();
        int nxt;
        nxt = (m_pc + 1) % MODV;
        if (!reset_n) begin
            m_pc = 0;
            m_ras.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (exc_req) begin
            m_pc = 'h3F0;
        end else if (!PC_write) begin
            m_pc = m_pc;
        end else if (ret_req) begin
            if (m_ras.size() > 0) begin
                m_pc = m_ras.pop_back();
            end else begin
                m_pc  = nxt;
                m_unf = 1;
            end
        end else if (jump_req) begin
            if (call) begin
                if (m_ras.size() == DEPTH) begin
                    void'(m_ras.pop_front());
                    m_ovf = 1;
                end
                m_ras.push_back(nxt);
            end
            m_pc = int'(jump_target);
        end else if (branch_req) begin
            m_pc = int'(branch_target);
        end else begin
            m_pc = nxt;
        end
    endtask

    task automatic clr();
        reset_n       = 1'b1;
        PC_write      = 1'b1;
        exc_req       = 1'b0;
        ret_req       = 1'b0;
        jump_req      = 1'b0;
        jump_target   = '0;
        call          = 1'b0;
        branch_req    = 1'b0;
        branch_target = '0;
    endtask

    task automatic tick();
        @(posedge clock);
        model_step();
        @(negedge clock);
    endtask

    task automatic do_jump(input int t, input bit c);
        clr();
        jump_req    = 1'b1;
        jump_target = AW'(t);
        call        = c;
        tick();
    endtask

    task automatic do_ret();
        clr();
        ret_req = 1'b1;
        tick();
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("pc_current", int'(PC_current), m_pc);
            check("pc_seq", int'(PC_seq), (m_pc + 1) % MODV);
            check("ras_empty", int'(ras_empty), int'(m_ras.size() == 0));
            check("ras_full", int'(ras_full), int'(m_ras.size() == DEPTH));
            check("ras_overflow", int'(ras_overflow), int'(m_ovf));
            check("ras_underflow", int'(ras_underflow), int'(m_unf));
        end
    end

    initial begin
        clr();
        reset_n = 1'b0;
        m_pc = 0;
        @(negedge clock);
        tick();
        tick();
        chk_en = 1'b1;
        check("rst_pc", int'(PC_current), 0);
        check("rst_empty", int'(ras_empty), 1);
        check("rst_seq", int'(PC_seq), 1);

        // Free run
        clr();
        tick(); check("run1", int'(PC_current), 1);
        tick(); check("run2", int'(PC_current), 2);
        tick(); check("run3", int'(PC_current), 3);
        tick(); tick(); check("run5", int'(PC_current), 5);

        // Stall with pending jump, then exception while stalled
        clr();
        PC_write = 1'b0; jump_req = 1'b1; jump_target = 10'd40;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall", int'(PC_current), 5);
        end
        exc_req = 1'b1;
        tick(); check("exc", int'(PC_current), 'h3F0);

        // Priority: jump beats branch, call pushes link
        do_jump(8, 0); check("jmp8", int'(PC_current), 8);
        clr();
        jump_req = 1'b1; jump_target = 10'd20; call = 1'b1;
        branch_req = 1'b1; branch_target = 10'd30;
        tick(); check("prio_jump", int'(PC_current), 20);
        check("prio_not_empty", int'(ras_empty), 0);
        clr(); branch_req = 1'b1; branch_target = 10'd30;
        tick(); check("branch", int'(PC_current), 30);
        do_ret(); check("ras_top9", int'(PC_current), 9);

        // Nested call/return
        do_jump(2, 0);
        do_jump(50, 1); check("call50", int'(PC_current), 50);
        clr(); tick(); check("seq51", int'(PC_current), 51);
        do_jump(70, 1); check("call70", int'(PC_current), 70);
        do_ret(); check("ret52", int'(PC_current), 52);
        do_ret(); check("ret3", int'(PC_current), 3);
        check("nest_empty", int'(ras_empty), 1);

        // Overflow then underflow
        for (int i = 1; i <= 5; i++) do_jump(100 * i, 1);
        check("ovf_full", int'(ras_full), 1);
        check("ovf_flag", int'(ras_overflow), 1);
        do_ret(); check("ret401", int'(PC_current), 401);
        do_ret(); check("ret301", int'(PC_current), 301);
        do_ret(); check("ret201", int'(PC_current), 201);
        do_ret(); check("ret101", int'(PC_current), 101);
        check("unf_before", int'(ras_underflow), 0);
        do_ret(); check("unf_pc", int'(PC_current), 102);
        check("unf_flag", int'(ras_underflow), 1);

        // Wrap-around
        do_jump('h3FF, 0); check("wrap_pc", int'(PC_current), 'h3FF);
        check("wrap_seq", int'(PC_seq), 0);
        clr(); tick(); check("wrap_next", int'(PC_current), 0);

        // Reset during stall with requests pending
        clr();
        reset_n = 1'b0; PC_write = 1'b0; ret_req = 1'b1; jump_req = 1'b1; exc_req = 1'b1;
        tick(); check("midrst_pc", int'(PC_current), 0);
        check("midrst_ovf", int'(ras_overflow), 0);
        check("midrst_unf", int'(ras_underflow), 0);
        clr(); tick(); check("post_rst", int'(PC_current), 1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset_n       = ($urandom_range(0, 199) != 0);
            PC_write      = ($urandom_range(0, 7) != 0);
            exc_req       = ($urandom_range(0, 24) == 0);
            ret_req       = ($urandom_range(0, 4) == 0);
            jump_req      = ($urandom_range(0, 3) == 0);
            call          = ($urandom_range(0, 1) == 0);
            branch_req    = ($urandom_range(0, 3) == 0);
            jump_target   = AW'($urandom);
            branch_target = AW'($urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the instruction-fetch stage. It replaces the plain PC register. It holds the fetch address and selects the next address each cycle from exception, return, jump, branch and sequential sources under a fixed priority. It also owns a small return-address stack (RAS) for call/return, and drives the instruction-memory address.

## Interface
Parameters:
- ADDR_W, 10, width of fetch address in bits
- STEP, 1, sequential increment added to PC each fetch
- RESET_VECTOR, 0, PC value loaded on reset
- EXC_VECTOR, 10'h3F0, PC value loaded on exception request
- RAS_DEPTH, 4, return-address stack entries (power of two, ≥2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  synchronous, active-low reset
- PC_write  in  1  1 = PC may advance; 0 = stall (hold)
- exc_req  in  1  exception redirect to EXC_VECTOR
- ret_req  in  1  return: next PC = RAS top, pop
- jump_req  in  1  unconditional jump to jump_target
- jump_target  in  ADDR_W  jump destination
- call  in  1  qualifier on jump_req: push link address
- branch_req  in  1  taken branch to branch_target
- branch_target  in  ADDR_W  branch destination
- PC_current  out  ADDR_W  registered fetch address to instruction memory
- PC_seq  out  ADDR_W  combinational PC_current + STEP (mod 2^ADDR_W)
- ras_empty  out  1  RAS holds 0 entries
- ras_full  out  1  RAS holds RAS_DEPTH entries
- ras_overflow  out  1  sticky: push occurred while full
- ras_underflow  out  1  sticky: ret_req taken while empty

## Operation
- Reset (reset_n=0 at edge):
  - PC_current=RESET_VECTOR.
  - RAS count=0, pointer=0.
  - ras_overflow=0, ras_underflow=0.
  - Reset overrides all other inputs.
- Next-PC priority at each edge, highest first:
  1. exc_req → EXC_VECTOR. Taken regardless of PC_write; RAS untouched.
  2. PC_write=0 → hold PC. No RAS change; ret/jump/branch/call ignored.
  3. ret_req → RAS top if non-empty, pop. If empty: PC_seq, set ras_underflow, no pop.
  4. jump_req → jump_target. If call=1, push PC_seq.
  5. branch_req → branch_target.
  6. Otherwise → PC_seq.
- call is ignored unless jump_req is the selected source (e.g. ret_req+jump_req+call: pop only, no push).
- RAS is circular, with write pointer and count (0..RAS_DEPTH):
  - Push writes entry[ptr], ptr+1 mod depth, count+1 saturating at RAS_DEPTH.
  - Push while full overwrites the oldest entry (count stays RAS_DEPTH) and sets ras_overflow.
  - Pop reads entry[ptr-1], ptr-1 mod depth, count-1.
- Arithmetic:
  - PC_seq wraps modulo 2^ADDR_W (all-ones + 1 → 0 when STEP=1).
  - Targets are used unmodified, no alignment check.
- Sticky flags clear only on reset.
- ras_empty = (count==0); ras_full = (count==RAS_DEPTH); both combinational from registered count.

## Timing
- Single-cycle latency: a request sampled at edge N appears on PC_current after edge N; no pipelining inside the block.
- PC_seq and RAS flags are valid in the same cycle as the state they derive from.
- Popped value is visible as PC_current one cycle after ret_req; the entry pushed by a call is available to a ret in the very next cycle.
- Flags update on the same edge as the offending push or pop.
- Reset asserted mid-operation (e.g. during a stall or with requests pending) wins on that edge; first post-reset fetch address is RESET_VECTOR.

## Test plan
- Reset then free-run, defaults: reset_n low 2 cycles → PC_current=0, then 0,1,2,3 on successive edges; ras_empty=1.
- Stall and exception: PC=5, PC_write=0 for 3 cycles with jump_req=1, target 40 → PC stays 5. Then exc_req=1 with PC_write=0 → PC=0x3F0.
- Priority: at PC=8 assert jump_req (20), branch_req (30) and call together → PC=20, RAS top=9. Next cycle branch_req=1 (30) alone → PC=30.
- Call/return nesting: calls from PC 2→50 and PC 51→70, then two ret_req → PC=52, then PC=3; ras_empty=1 at end.
- Overflow and underflow: 5 calls with RAS_DEPTH=4 → ras_full=1, ras_overflow=1, first link lost. 4 rets return the last four links in reverse. A fifth ret → PC=PC_seq, ras_underflow=1.
- Wrap-around: force PC=0x3FF via jump → next sequential PC=0x000; PC_seq=0x000 while PC=0x3FF.
